// File: rtl/dram_port_arbiter.sv
// Two-master arbiter for the single DRAM port: one registered RD/WR strobe per
// access, a fixed wait for memory latency, then read data back to the owner.
module dram_port_arbiter #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 1,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [15:0] m1_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        WR_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        owner_r;
    logic        we_r;
    logic        last_r;

    logic        win_s;
    logic        sel_we_s;
    logic [15:0] sel_addr_s;
    logic [15:0] sel_wdata_s;

    // Pick the winner among current requesters and mux its request fields
    always_comb begin
        win_s       = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = 16'h0000;
        sel_wdata_s = 16'h0000;
        if (m0_req && m1_req) begin
            if (RR_EN) begin
                win_s = ~last_r;
            end else begin
                win_s = 1'b0;
            end
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
    end

    // Access sequencer; every output is a register so the DRAM pins stay glitch-free
    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            owner_r   <= 1'b0;
            we_r      <= 1'b0;
            last_r    <= 1'b1;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 16'h0000;
            m1_rdata  <= 16'h0000;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        // mem_addr/mem_wdata are loaded here and then held through the wait
                        state_r   <= ISSUE;
                        owner_r   <= win_s;
                        last_r    <= win_s;
                        we_r      <= sel_we_s;
                        mem_addr  <= sel_addr_s;
                        mem_wdata <= sel_wdata_s;
                        mem_rd    <= ~sel_we_s;
                        mem_wr    <= sel_we_s;
                        m0_gnt    <= ~win_s;
                        m1_gnt    <= win_s;
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (we_r) begin
                        state_r <= WR_WAIT;
                        cnt_r   <= WR_LOAD;
                    end else begin
                        state_r <= RD_WAIT;
                        cnt_r   <= RD_LOAD;
                    end
                end
                RD_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        if (owner_r) begin
                            m1_rdata  <= mem_rdata;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= mem_rdata;
                            m0_rvalid <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: a round-robin instance checked in detail
// and a fixed-priority instance sharing the same master stimulus.
module tb_dram_port_arbiter;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, busy;

    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [15:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
    logic        fp_mem_rd, fp_mem_wr, fp_busy;

    logic [15:0] dram [0:65535];
    int          n_total = 0;
    int          n_bad   = 0;
    logic        mon_en  = 1'b0;

    always #5 Clk1 = ~Clk1;

    dram_port_arbiter #(.RD_LAT(2), .WR_LAT(1), .RR_EN(1'b1)) u_dut (
        .Clk1(Clk1), .Reset(Reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dram_port_arbiter #(.RD_LAT(2), .WR_LAT(1), .RR_EN(1'b0)) u_fp (
        .Clk1(Clk1), .Reset(Reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_rd(fp_mem_rd), .mem_wr(fp_mem_wr),
        .mem_rdata(fp_mem_rdata), .busy(fp_busy)
    );

    assign mem_rdata    = dram[mem_addr];
    assign fp_mem_rdata = dram[fp_mem_addr];

    // DRAM model: only the round-robin instance writes memory
    always @(posedge Clk1) begin
        if (mem_wr) dram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk1);
    endtask

    // Strobe exclusivity on both instances, every cycle once reset has settled
    always @(negedge Clk1) begin
        if (mon_en) begin
            chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
            chk("fp_rd_wr_excl", {31'd0, fp_mem_rd & fp_mem_wr}, 32'd0);
        end
    end

    initial begin
        int order [6];
        int ng, v0, v1, fg0, fg1, nrv;
        logic [15:0] exp_m0, exp_m1;

        dram[16'h0010] = 16'hBEEF;
        dram[16'h0020] = 16'h1111;
        dram[16'h0030] = 16'h2222;
        dram[16'h00FF] = 16'h0000;
        dram[16'hFFFF] = 16'h0000;

        Reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010; m0_wdata = 16'h0000;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0000; m1_wdata = 16'h0000;

        // reset held 3 cycles with m0 requesting
        repeat (3) tick();
        mon_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_m0_rdata", {16'd0, m0_rdata}, 32'd0);
        Reset = 1'b1;

        // first grant to m0, read of 0x0010
        tick();
        chk("rd_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("rd_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("rd_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("rd_mem_addr", {16'd0, mem_addr}, 32'h0010);
        m0_req = 1'b0;
        tick();
        chk("rd_strobe_once", {31'd0, mem_rd}, 32'd0);
        chk("rd_addr_hold", {16'd0, mem_addr}, 32'h0010);
        chk("rd_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("rd_early_rvalid", {31'd0, m0_rvalid}, 32'd0);
        tick();
        chk("rd_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("rd_m0_rdata", {16'd0, m0_rdata}, 32'hBEEF);
        chk("rd_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("rd_idle", {31'd0, busy}, 32'd0);

        // m1 writes 0x1234 to 0x00FF
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h00FF; m1_wdata = 16'h1234;
        tick();
        chk("wr_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("wr_mem_addr", {16'd0, mem_addr}, 32'h00FF);
        chk("wr_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
        m1_req = 1'b0;
        tick();
        chk("wr_strobe_once", {31'd0, mem_wr}, 32'd0);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("wr_idle", {31'd0, busy}, 32'd0);
        chk("wr_no_rvalid", {31'd0, m1_rvalid}, 32'd0);

        // m0 reads back 0x00FF
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h00FF;
        tick();
        chk("rb_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        m0_req = 1'b0;
        repeat (3) tick();
        chk("rb_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("rb_m0_rdata", {16'd0, m0_rdata}, 32'h1234);

        // reset pulse so the pointer favours m0, then both masters stream reads
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0020;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0030;
        ng = 0; v0 = 0; v1 = 0; fg0 = 0; fg1 = 0;
        exp_m0 = 16'h0000; exp_m1 = 16'h0000;
        for (int c = 0; c < 60 && (ng < 6 || v0 + v1 < 6); c++) begin
            tick();
            if (m0_gnt) begin if (ng < 6) order[ng] = 0; ng++; end
            if (m1_gnt) begin if (ng < 6) order[ng] = 1; ng++; end
            if (fp_m0_gnt) fg0++;
            if (fp_m1_gnt) fg1++;
            if (m0_rvalid) begin
                v0++;
                exp_m0 = 16'h1111;
                chk("rr_m0_rdata", {16'd0, m0_rdata}, {16'd0, exp_m0});
                chk("rr_m1_rdata_hold", {16'd0, m1_rdata}, {16'd0, exp_m1});
                chk("rr_m0_only", {31'd0, m1_rvalid}, 32'd0);
            end
            if (m1_rvalid) begin
                v1++;
                exp_m1 = 16'h2222;
                chk("rr_m1_rdata", {16'd0, m1_rdata}, {16'd0, exp_m1});
                chk("rr_m0_rdata_hold", {16'd0, m0_rdata}, {16'd0, exp_m0});
            end
            if (ng >= 6) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
        chk("rr_grant_count", ng, 32'd6);
        for (int i = 0; i < 6; i++) chk("rr_order", order[i], i % 2);
        chk("rr_m0_rvalids", v0, 32'd3);
        chk("rr_m1_rvalids", v1, 32'd3);
        chk("fp_m0_grants", fg0, 32'd6);
        chk("fp_m1_grants", fg1, 32'd0);

        // reset during RD_WAIT abandons the read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        tick();
        chk("ab_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        m0_req = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        Reset = 1'b1;
        nrv = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            nrv += int'(m0_rvalid) + int'(m1_rvalid);
        end
        chk("ab_no_rvalid", nrv, 32'd0);
        chk("ab_idle", {31'd0, busy}, 32'd0);

        // m1 write to 0xFFFF, m0 read of 0xFFFF arrives during it
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'hFFFF; m1_wdata = 16'hA5A5;
        tick();
        chk("wf_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        chk("wf_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("wf_mem_addr", {16'd0, mem_addr}, 32'hFFFF);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'hFFFF;
        tick();
        chk("wf_wait_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("wf_wait_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("wf_idle_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        tick();
        chk("wf_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("wf_mem_rd", {31'd0, mem_rd}, 32'd1);
        m0_req = 1'b0;
        repeat (3) tick();
        chk("wf_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("wf_m0_rdata", {16'd0, m0_rdata}, 32'hA5A5);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Two-master arbiter that shares the single DRAM port between the CVP14 core (master 0) and a debug/DMA master (master 1), e.g. a memory load/dump engine.
- Sequences every access as one registered RD or WR strobe, waits a fixed memory latency, then returns read data to the owning master.
- Sits between the masters and the DRAM's Addr/DataIn/DataOut/RD/WR pins.

Parameters:
- RD_LAT, 2, cycles from the mem_rd strobe cycle to the cycle mem_rdata is sampled (range 1..15).
- WR_LAT, 1, cycles the arbiter stays busy after the mem_wr strobe before accepting a new request (range 1..15).
- RR_EN, 1, 1 = round-robin between masters; 0 = fixed priority, master 0 always wins.

Ports:
- Clk1  in  1  single clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- m0_req, m1_req  in  1  access request; held until the matching gnt.
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req is high.
- m0_addr, m1_addr  in  16  word address; stable while req is high.
- m0_wdata, m1_wdata  in  16  write data; stable while req is high.
- m0_gnt, m1_gnt  out  1  one-cycle pulse; the request was issued to memory this cycle.
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse; m*_rdata is valid.
- m0_rdata, m1_rdata  out  16  read data; holds its last value between rvalid pulses.
- mem_addr  out  16  DRAM address.
- mem_wdata  out  16  DRAM write data.
- mem_rd, mem_wr  out  1  DRAM strobes; never both high.
- mem_rdata  in  16  DRAM read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (Reset == 0 at a rising edge):
  - All outputs go to 0; state goes to IDLE; last-grant pointer goes to master 1, so master 0 wins the first tie.
  - A reset mid-operation abandons the access. No rvalid pulse follows, including for a read already strobed.
- States: IDLE, ISSUE, RD_WAIT, WR_WAIT.
- IDLE:
  - If any req is high, select a winner and go to ISSUE.
  - Latch the winner's addr, wdata and we; register the winner ID.
- Winner selection:
  - RR_EN = 1 and both requesting: the master not granted last.
  - RR_EN = 0: master 0 whenever m0_req is high.
  - Only one requesting: that master.
- ISSUE (exactly one cycle):
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_rd = !we, mem_wr = we.
  - The winner's gnt pulses high; the last-grant pointer updates.
  - Next state is RD_WAIT (read) or WR_WAIT (write).
  - The master may drop req or present a new request in the cycle after gnt.
- RD_WAIT:
  - The counter loads RD_LAT−1 on entry. mem_rdata is sampled in the cycle the counter reaches 0, i.e. RD_LAT cycles after the ISSUE cycle.
  - The owner's rdata is registered and its rvalid pulses on the following cycle. Load-to-use latency is RD_LAT+1 cycles after gnt.
  - Then go to IDLE.
- WR_WAIT: stay WR_LAT cycles, then go to IDLE. No rvalid for writes.
- Strobes and address outside ISSUE:
  - mem_rd and mem_wr are 0 outside ISSUE.
  - mem_addr and mem_wdata hold their last values, so the DRAM address is stable through the wait.
- Throughput: with a request waiting, the minimum issue spacing is 1 (IDLE) + 1 (ISSUE) + RD_LAT or WR_LAT cycles.
- Starvation: with RR_EN = 1 and both masters requesting continuously, grants strictly alternate.
- Requests arriving during a non-IDLE state are not sampled until IDLE. A req dropped before gnt is a protocol violation; the latched request is still issued.
- The m1 rdata/rvalid outputs never change on a master-0 transaction, and vice versa.
- Counter width: 4 bits; no wrap is possible within the parameter range.

Test Plan:
- Reset held low 3 cycles with m0_req = 1 → all outputs 0, busy = 0; the first grant goes to m0 one cycle after Reset rises.
- m0 reads 0x0010 with DRAM[0x0010] = 0xBEEF, RD_LAT = 2:
  - mem_rd is high exactly one cycle with mem_addr = 0x0010.
  - m0_rvalid pulses 3 cycles after m0_gnt with m0_rdata = 0xBEEF.
  - m1_rvalid stays 0.
- m1 writes 0x1234 to 0x00FF → mem_wr is a single pulse with mem_addr = 0x00FF and mem_wdata = 0x1234; a later m0 read of 0x00FF returns 0x1234.
- Both masters requesting reads continuously for 6 grants, RR_EN = 1 → grant order m0, m1, m0, m1, m0, m1; each rdata is routed only to its owner. With RR_EN = 0 → all grants go to m0 while m0_req is held.
- Reset asserted the cycle after a read ISSUE → no rvalid on either master; state is IDLE and busy = 0 after reset.
- m1 issues a write to 0xFFFF while m0 requests a read → the write completes, then m0 is granted. mem_rd and mem_wr are never high together (checked by assertion throughout).
